manchester_frame_sync: RTL and testbench

Parametrised successor to the fixed-layout serial frame decoder. Consumes the decoded Manchester bit strobe from the edge/state-machine front end and hunts for a programmable preamble in a sliding window, so it no longer relies on a start edge. It then captures a fixed-length payload, checks masked constant fields, and commits only good frames to a double-buffered output register. Sits between the Manchester state machine and the field split/display logic in the top level.

---
 rtl/manchester_frame_sync_pkg.sv | 7 +
 rtl/manchester_frame_sync_if.sv | 21 ++
 rtl/manchester_frame_sync_sat_counter.sv | 14 +
 rtl/manchester_frame_sync.sv | 126 ++++++++++++
 tb/tb_manchester_frame_sync.sv | 128 ++++++++++++
 5 files changed

// File: rtl/manchester_frame_sync_pkg.sv
// mfs_pkg: shared FSM state type and error_code values for the frame sync block
package mfs_pkg;
  typedef enum logic [1:0] {HUNT, CAPTURE, CHECK} state_t;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CHECK = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
endpackage

// File: rtl/manchester_frame_sync_if.sv
// manchester_frame_sync_if: bit strobe/restart in, frame results and counters out (master drives bits, slave decodes)
interface manchester_frame_sync_if #(parameter int FRAME_BITS = 160);
  logic restart;
  logic serial_clock;
  logic serial_data;
  logic [FRAME_BITS-1:0] frame_data;
  logic frame_valid;
  logic frame_error;
  logic [1:0] error_code;
  logic busy;
  logic [7:0] frames_ok;
  logic [7:0] frames_bad;
  modport master (
    output restart, serial_clock, serial_data,
    input frame_data, frame_valid, frame_error, error_code, busy, frames_ok, frames_bad
  );
  modport slave (
    input restart, serial_clock, serial_data,
    output frame_data, frame_valid, frame_error, error_code, busy, frames_ok, frames_bad
  );
endinterface

// File: rtl/manchester_frame_sync_sat_counter.sv
// sat_counter: clock/reset/inc in, count out; counts inc pulses and holds at all-ones
module sat_counter #(parameter int WIDTH = 8) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_q, count_d;
  always_comb count_d = (inc && count_q != '1) ? count_q + 1'b1 : count_q;
  always_ff @(posedge clock or posedge reset)
    if (reset) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/manchester_frame_sync.sv
// manchester_frame_sync: clock/reset plus slave bus; hunts a sliding-window preamble, captures and checks a payload, commits good frames
module manchester_frame_sync
  import mfs_pkg::*;
#(
  parameter int unsigned PREAMBLE_BITS = 32,
  parameter logic [PREAMBLE_BITS-1:0] PREAMBLE = 32'hFFFF_FFFF,
  parameter int unsigned FRAME_BITS = 160,
  parameter logic [FRAME_BITS-1:0] CHECK_MASK = 160'h0,
  parameter logic [FRAME_BITS-1:0] CHECK_VALUE = 160'h0,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input logic clock,
  input logic reset,
  manchester_frame_sync_if.slave bus
);
  localparam int PW = $clog2(PREAMBLE_BITS + 1);
  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PW-1:0] PRE_FULL = PW'(PREAMBLE_BITS);
  localparam logic [PW-1:0] PRE_ARM = PW'(PREAMBLE_BITS - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);
  state_t state_q, state_d;
  logic [PREAMBLE_BITS-1:0] pre_sr_q, pre_sr_d, pre_shift;
  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic [FRAME_BITS-1:0] frame_sr_q, frame_sr_d, frame_shift;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [FRAME_BITS-1:0] frame_data_q, frame_data_d;
  logic frame_valid_q, frame_valid_d;
  logic frame_error_q, frame_error_d;
  logic [1:0] error_code_q, error_code_d;
  logic strobe, check_ok;
  assign strobe = bus.serial_clock;
  assign pre_shift = PREAMBLE_BITS'({pre_sr_q, bus.serial_data});
  assign frame_shift = FRAME_BITS'({frame_sr_q, bus.serial_data});
  assign check_ok = (frame_sr_q & CHECK_MASK) == CHECK_VALUE;
  // Every path back to HUNT wipes the preamble window so a stale window can never match.
  always_comb begin
    state_d = state_q;
    pre_sr_d = pre_sr_q;
    pre_cnt_d = pre_cnt_q;
    frame_sr_d = frame_sr_q;
    bit_cnt_d = bit_cnt_q;
    idle_d = idle_q;
    frame_data_d = frame_data_q;
    frame_valid_d = 1'b0;
    frame_error_d = 1'b0;
    error_code_d = error_code_q;
    if (bus.restart) begin
      state_d = HUNT;
      pre_sr_d = '0;
      pre_cnt_d = '0;
      bit_cnt_d = '0;
      idle_d = '0;
    end else begin
      case (state_q)
        HUNT: if (strobe) begin
          pre_sr_d = pre_shift;
          pre_cnt_d = pre_cnt_q + PW'(pre_cnt_q != PRE_FULL);
          // Once the window is full it keeps sliding, so noise ahead of the preamble is tolerated.
          if (pre_cnt_q >= PRE_ARM && pre_shift == PREAMBLE) begin
            state_d = CAPTURE;
            bit_cnt_d = '0;
            idle_d = '0;
          end
        end
        CAPTURE: if (strobe) begin
          frame_sr_d = frame_shift;
          bit_cnt_d = bit_cnt_q + 1'b1;
          idle_d = '0;
          state_d = (bit_cnt_q == BIT_LAST) ? CHECK : CAPTURE;
        end else if (idle_q == IDLE_LAST) begin
          state_d = HUNT;
          pre_sr_d = '0;
          pre_cnt_d = '0;
          frame_error_d = 1'b1;
          error_code_d = ERR_TIMEOUT;
        end else begin
          idle_d = idle_q + 1'b1;
        end
        CHECK: begin
          state_d = HUNT;
          pre_sr_d = '0;
          pre_cnt_d = '0;
          frame_data_d = check_ok ? frame_sr_q : frame_data_q;
          frame_valid_d = check_ok;
          frame_error_d = !check_ok;
          error_code_d = check_ok ? ERR_NONE : ERR_CHECK;
        end
        default: state_d = HUNT;
      endcase
    end
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= HUNT;
      pre_sr_q <= '0;
      pre_cnt_q <= '0;
      frame_sr_q <= '0;
      bit_cnt_q <= '0;
      idle_q <= '0;
      frame_data_q <= '0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      error_code_q <= ERR_NONE;
    end else begin
      state_q <= state_d;
      pre_sr_q <= pre_sr_d;
      pre_cnt_q <= pre_cnt_d;
      frame_sr_q <= frame_sr_d;
      bit_cnt_q <= bit_cnt_d;
      idle_q <= idle_d;
      frame_data_q <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      frame_error_q <= frame_error_d;
      error_code_q <= error_code_d;
    end
  sat_counter #(.WIDTH(8)) u_ok (.clock(clock), .reset(reset), .inc(frame_valid_d), .count(bus.frames_ok));
  sat_counter #(.WIDTH(8)) u_bad (.clock(clock), .reset(reset), .inc(frame_error_d), .count(bus.frames_bad));
  assign bus.frame_data = frame_data_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_error = frame_error_q;
  assign bus.error_code = error_code_q;
  assign bus.busy = state_q != HUNT;
endmodule

// File: tb/tb_manchester_frame_sync.sv
// tb_manchester_frame_sync: directed frames against manchester_frame_sync with hand-computed expectations
module tb_manchester_frame_sync;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  manchester_frame_sync_if #(.FRAME_BITS(16)) bus ();
  manchester_frame_sync #(
    .PREAMBLE_BITS(8), .PREAMBLE(8'hA5), .FRAME_BITS(16),
    .CHECK_MASK(16'hFF00), .CHECK_VALUE(16'h3C00), .TIMEOUT_CYCLES(20)
  ) dut (.clock(clk), .reset(rst), .bus(bus));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send_bit(input logic b);
    repeat (3) @(negedge clk);
    bus.serial_clock = 1'b1;
    bus.serial_data = b;
    @(negedge clk);
    bus.serial_clock = 1'b0;
  endtask
  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask
  task automatic send_frame(input logic [15:0] payload);
    send_bits(32'hA5, 8);
    send_bits({16'h0, payload}, 16);
  endtask
  task automatic expect_valid(input string tag, input logic [15:0] data, input logic [7:0] ok);
    check({tag, "_valid_early"}, bus.frame_valid, 1'b0);
    @(negedge clk);
    check({tag, "_valid"}, bus.frame_valid, 1'b1);
    check({tag, "_error"}, bus.frame_error, 1'b0);
    check({tag, "_data"}, bus.frame_data, data);
    check({tag, "_ok"}, bus.frames_ok, ok);
    check({tag, "_code"}, bus.error_code, 2'd0);
    @(negedge clk);
    check({tag, "_valid_late"}, bus.frame_valid, 1'b0);
  endtask
  task automatic expect_error(input string tag, input logic [1:0] code, input logic [7:0] bad, input logic [15:0] data);
    check({tag, "_error_early"}, bus.frame_error, 1'b0);
    @(negedge clk);
    check({tag, "_error"}, bus.frame_error, 1'b1);
    check({tag, "_valid"}, bus.frame_valid, 1'b0);
    check({tag, "_code"}, bus.error_code, code);
    check({tag, "_bad"}, bus.frames_bad, bad);
    check({tag, "_data"}, bus.frame_data, data);
    check({tag, "_busy"}, bus.busy, 1'b0);
    @(negedge clk);
    check({tag, "_error_late"}, bus.frame_error, 1'b0);
    check({tag, "_code_held"}, bus.error_code, code);
  endtask
  initial begin
    bus.restart = 1'b0;
    bus.serial_clock = 1'b0;
    bus.serial_data = 1'b0;
    #1;
    check("rst_data", bus.frame_data, 16'h0);
    check("rst_valid", bus.frame_valid, 1'b0);
    check("rst_error", bus.frame_error, 1'b0);
    check("rst_code", bus.error_code, 2'd0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_ok", bus.frames_ok, 8'd0);
    check("rst_bad", bus.frames_bad, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    send_bits(32'hA5, 8);
    check("t1_busy", bus.busy, 1'b1);
    send_bits(32'h3C7E, 16);
    expect_valid("t1", 16'h3C7E, 8'd1);
    send_frame(16'h127E);
    expect_error("t2", 2'd1, 8'd1, 16'h3C7E);
    send_bits(32'hFF, 8);
    check("t3_noise_idle", bus.busy, 1'b0);
    send_frame(16'h3C01);
    expect_valid("t3", 16'h3C01, 8'd2);
    send_bits(32'hA5, 8);
    send_bits(32'h15, 5);
    check("t4_busy_start", bus.busy, 1'b1);
    repeat (19) @(negedge clk);
    check("t4_busy_before", bus.busy, 1'b1);
    expect_error("t4", 2'd2, 8'd2, 16'h3C01);
    send_frame(16'h3C55);
    expect_valid("t4_after", 16'h3C55, 8'd3);
    send_bits(32'hA5, 8);
    send_bits(32'h9, 4);
    @(negedge clk);
    bus.restart = 1'b1;
    @(negedge clk);
    bus.restart = 1'b0;
    check("t5_busy", bus.busy, 1'b0);
    check("t5_valid", bus.frame_valid, 1'b0);
    check("t5_error", bus.frame_error, 1'b0);
    check("t5_code", bus.error_code, 2'd0);
    check("t5_bad", bus.frames_bad, 8'd2);
    check("t5_data", bus.frame_data, 16'h3C55);
    send_frame(16'h3CAA);
    expect_valid("t5", 16'h3CAA, 8'd4);
    send_bits(32'hA5, 8);
    send_bits(32'h5, 3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("ar_data", bus.frame_data, 16'h0);
    check("ar_busy", bus.busy, 1'b0);
    check("ar_ok", bus.frames_ok, 8'd0);
    check("ar_bad", bus.frames_bad, 8'd0);
    check("ar_code", bus.error_code, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 260; i++) begin
      send_frame({8'h3C, 8'(i)});
      @(negedge clk);
      if (i == 0) check("t6_first", bus.frames_ok, 8'd1);
      if (i == 254) check("t6_at_255", bus.frames_ok, 8'd255);
    end
    check("t6_sat", bus.frames_ok, 8'd255);
    check("t6_data", bus.frame_data, 16'h3C03);
    check("t6_bad", bus.frames_bad, 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
